// File: rtl/lenet_pool_if.sv
// Pixel-tap and LeNet-memory write bundle for the frame downsampler.
interface lenet_pool_if;
  logic       start;
  logic       pix_valid;
  logic       pix_sof;
  logic [3:0] pix_data;
  logic       busy;
  logic       img_we;
  logic [9:0] img_addr;
  logic [7:0] img_data;
  logic       done;

  modport master (
    output start, pix_valid, pix_sof, pix_data,
    input  busy, img_we, img_addr, img_data, done
  );

  modport slave (
    input  start, pix_valid, pix_sof, pix_data,
    output busy, img_we, img_addr, img_data, done
  );
endinterface

// File: rtl/lenet_pool.sv
// Averages the centred window of the scan-out pixel stream into the LeNet input
// image, one block sum per output pixel, one frame per start request.
module lenet_pool #(
  parameter int unsigned widthlength  = 8,
  parameter int unsigned heightlength = 8,
  parameter int unsigned lenet_size   = 28,
  parameter int unsigned hRez         = 640,
  parameter int unsigned vRez         = 480
) (
  input  logic         clk25,
  input  logic         rst_n,
  lenet_pool_if.slave  bus
);
  localparam int unsigned CW        = 10;
  localparam int unsigned ACC_W     = 10;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned WIN_W     = widthlength * lenet_size;
  localparam int unsigned WIN_H     = heightlength * lenet_size;
  localparam int unsigned LEFT      = hRez / 2 - WIN_W / 2;
  localparam int unsigned TOP       = vRez / 2 - WIN_H / 2;
  localparam int unsigned BX_W      = $clog2(lenet_size);
  localparam int unsigned LAST_ADDR = lenet_size * lenet_size - 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] ACCUM = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state, state_n;
  logic [CW-1:0]     x, y, x_n, y_n;
  logic [ACC_W-1:0]  acc [lenet_size];

  logic [CW-1:0]     cur_x, cur_y, dx, dy;
  logic              take, in_win, closing;
  logic [BX_W-1:0]   bx, by;
  logic [ACC_W-1:0]  sum;
  logic              clr_all, acc_we;
  logic [ACC_W-1:0]  acc_wval;
  logic              we_n, done_n, busy_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] data_n;

  // Next state, pixel position, accumulator update and write generation.
  always_comb begin
    state_n  = state;
    x_n      = x;
    y_n      = y;
    cur_x    = x;
    cur_y    = y;
    take     = 1'b0;
    clr_all  = 1'b0;
    acc_we   = 1'b0;
    acc_wval = '0;
    we_n     = 1'b0;
    done_n   = 1'b0;
    addr_n   = bus.img_addr;
    data_n   = bus.img_data;

    case (state)
      IDLE:  if (bus.start) state_n = ARMED;
      ARMED: if (bus.pix_valid && bus.pix_sof) begin
               take    = 1'b1;
               cur_x   = '0;
               cur_y   = '0;
               state_n = ACCUM;
             end
      ACCUM: if (bus.pix_valid) begin
               take = 1'b1;
               // An early sof restarts the pass from the top-left corner.
               if (bus.pix_sof) begin
                 clr_all = 1'b1;
                 cur_x   = '0;
                 cur_y   = '0;
               end
             end
      DONE:  begin
               done_n  = 1'b1;
               state_n = IDLE;
             end
      default: state_n = IDLE;
    endcase

    dx      = cur_x - CW'(LEFT);
    dy      = cur_y - CW'(TOP);
    in_win  = (cur_x >= CW'(LEFT)) && (cur_x < CW'(LEFT + WIN_W)) &&
              (cur_y >= CW'(TOP))  && (cur_y < CW'(TOP + WIN_H));
    bx      = BX_W'(32'(dx) / widthlength);
    by      = BX_W'(32'(dy) / heightlength);
    closing = ((32'(dx) % widthlength) == widthlength - 1) &&
              ((32'(dy) % heightlength) == heightlength - 1);
    sum     = acc[bx] + ACC_W'(bus.pix_data);

    if (take) begin
      if (cur_x == CW'(hRez - 1)) begin
        x_n = '0;
        y_n = cur_y + CW'(1);
      end else begin
        x_n = cur_x + CW'(1);
        y_n = cur_y;
      end
      if (in_win) begin
        acc_we = 1'b1;
        if (closing) begin
          acc_wval = '0;
          we_n     = 1'b1;
          addr_n   = ADDR_W'(32'(by) * lenet_size + 32'(bx));
          data_n   = DATA_W'(sum >> 2);
          if (addr_n == ADDR_W'(LAST_ADDR)) state_n = DONE;
        end else begin
          acc_wval = sum;
        end
      end
    end

    busy_n = (state_n != IDLE) || done_n;
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      x            <= '0;
      y            <= '0;
      bus.busy     <= 1'b0;
      bus.img_we   <= 1'b0;
      bus.img_addr <= '0;
      bus.img_data <= '0;
      bus.done     <= 1'b0;
    end else begin
      state        <= state_n;
      x            <= x_n;
      y            <= y_n;
      bus.busy     <= busy_n;
      bus.img_we   <= we_n;
      bus.img_addr <= addr_n;
      bus.img_data <= data_n;
      bus.done     <= done_n;
    end
  end

  // Per-column block accumulators; a restart clears all before this pixel lands.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(lenet_size); i++) acc[i] <= '0;
    end else begin
      if (clr_all)
        for (int i = 0; i < int'(lenet_size); i++) acc[i] <= '0;
      if (acc_we) acc[bx] <= acc_wval;
    end
  end
endmodule

// File: tb/tb_lenet_pool.sv
// Directed bench for lenet_pool on a reduced 48x40 frame with a 4x4-block window.
module tb_lenet_pool;
  // Window geometry for the reduced frame, worked by hand: left = 24-16, top = 20-16.
  localparam int HR    = 48;
  localparam int VR    = 40;
  localparam int N_BLK = 16;

  logic clk25 = 1'b0;
  logic rst_n = 1'b0;
  lenet_pool_if bus();

  lenet_pool #(
    .widthlength(8), .heightlength(8), .lenet_size(4), .hRez(HR), .vRez(VR)
  ) dut (
    .clk25 (clk25),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #20 clk25 = ~clk25;

  int n_chk  = 0;
  int n_pass = 0;

  logic       mon_clr = 1'b0;
  int         cyc = 0, wr_cnt = 0, done_cnt = 0, last_we = 0, done_lat = 0;
  logic       order_ok = 1'b1;
  logic [7:0] mem [N_BLK];

  always @(negedge clk25) begin
    cyc <= cyc + 1;
    if (mon_clr) begin
      wr_cnt   <= 0;
      done_cnt <= 0;
      order_ok <= 1'b1;
      for (int i = 0; i < N_BLK; i++) mem[i] <= 8'hFF;
    end else begin
      if (bus.img_we) begin
        if (int'(bus.img_addr) != wr_cnt) order_ok <= 1'b0;
        if (int'(bus.img_addr) < N_BLK) mem[bus.img_addr[3:0]] <= bus.img_data;
        wr_cnt  <= wr_cnt + 1;
        last_we <= cyc;
      end
      if (bus.done) begin
        done_cnt <= done_cnt + 1;
        done_lat <= cyc - last_we;
      end
    end
  end

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  function automatic logic [3:0] pix_of(input int mode, input logic [3:0] uval,
                                        input int x, input int y);
    case (mode)
      1:       return (x >= 8 && x <= 15 && y >= 4 && y <= 11) ? 4'd1 : 4'd0;
      2:       return (x == 39 && y == 35) ? 4'd15 : 4'd0;
      default: return uval;
    endcase
  endfunction

  // One frame of pixels; stop_y truncates it, st1/st2 raise start at x=0 of those lines.
  task automatic drive_frame(input int mode, input logic [3:0] uval, input bit gaps,
                             input int stop_y, input int st1, input int st2);
    int n;
    for (int y = 0; y < VR; y++) begin
      for (int x = 0; x < HR; x++) begin
        if (y == stop_y) begin
          bus.pix_valid = 1'b0;
          bus.pix_sof   = 1'b0;
          return;
        end
        bus.pix_valid = 1'b1;
        bus.pix_sof   = (x == 0 && y == 0);
        bus.pix_data  = pix_of(mode, uval, x, y);
        bus.start     = (x == 0 && (y == st1 || y == st2));
        tick();
        bus.start = 1'b0;
        if (gaps) begin
          n = $urandom_range(0, 2);
          bus.pix_valid = 1'b0;
          bus.pix_sof   = 1'b0;
          repeat (n) tick();
        end
      end
      bus.pix_valid = 1'b0;
      bus.pix_sof   = 1'b0;
      tick();
      tick();
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.pix_valid = 1'b0; bus.pix_sof = 1'b0; bus.pix_data = 4'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_we", 32'(bus.img_we), 32'd0);
    check("rst_addr", 32'(bus.img_addr), 32'd0);
    check("rst_data", 32'(bus.img_data), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);

    // Uniform 15: every block sums 960, writes 240.
    pulse_start();
    clear_mon();
    drive_frame(0, 4'd15, 1'b0, -1, -1, -1);
    repeat (4) tick();
    check("u15_wr_cnt", 32'(wr_cnt), 32'd16);
    check("u15_order", 32'(order_ok), 32'd1);
    for (int i = 0; i < N_BLK; i++) check($sformatf("u15_data%0d", i), 32'(mem[i]), 32'd240);
    check("u15_done_cnt", 32'(done_cnt), 32'd1);
    check("u15_done_lat", 32'(done_lat), 32'd1);
    check("u15_busy_end", 32'(bus.busy), 32'd0);

    // Ones in the first block only.
    pulse_start();
    clear_mon();
    drive_frame(1, 4'd0, 1'b0, -1, -1, -1);
    repeat (4) tick();
    check("blk_wr_cnt", 32'(wr_cnt), 32'd16);
    check("blk_data0", 32'(mem[0]), 32'd16);
    for (int i = 1; i < N_BLK; i++) check($sformatf("blk_data%0d", i), 32'(mem[i]), 32'd0);
    check("blk_done_cnt", 32'(done_cnt), 32'd1);

    // Single 15 on the last window pixel.
    pulse_start();
    clear_mon();
    drive_frame(2, 4'd0, 1'b0, -1, -1, -1);
    repeat (4) tick();
    check("last_data15", 32'(mem[15]), 32'd3);
    check("last_data14", 32'(mem[14]), 32'd0);
    check("last_data0", 32'(mem[0]), 32'd0);

    // Start mid-frame, second start while busy.
    clear_mon();
    drive_frame(0, 4'd15, 1'b0, -1, 10, 20);
    check("mid_no_writes", 32'(wr_cnt), 32'd0);
    check("mid_busy", 32'(bus.busy), 32'd1);
    drive_frame(0, 4'd15, 1'b0, -1, -1, -1);
    repeat (4) tick();
    check("mid_wr_cnt", 32'(wr_cnt), 32'd16);
    check("mid_order", 32'(order_ok), 32'd1);
    check("mid_done_cnt", 32'(done_cnt), 32'd1);
    check("mid_busy_end", 32'(bus.busy), 32'd0);

    // Early sof at y=22 leaves row 2 partially summed; restart must discard it.
    pulse_start();
    clear_mon();
    drive_frame(0, 4'd15, 1'b0, 22, -1, -1);
    check("abort_wr_cnt", 32'(wr_cnt), 32'd8);
    check("abort_done", 32'(done_cnt), 32'd0);
    clear_mon();
    drive_frame(0, 4'd15, 1'b0, -1, -1, -1);
    repeat (4) tick();
    check("restart_wr_cnt", 32'(wr_cnt), 32'd16);
    check("restart_order", 32'(order_ok), 32'd1);
    for (int i = 0; i < N_BLK; i++) check($sformatf("restart_data%0d", i), 32'(mem[i]), 32'd240);
    check("restart_done", 32'(done_cnt), 32'd1);

    // Random gaps, uniform 8: 64*8 >> 2 = 128.
    pulse_start();
    clear_mon();
    drive_frame(0, 4'd8, 1'b1, -1, -1, -1);
    repeat (4) tick();
    check("gap_wr_cnt", 32'(wr_cnt), 32'd16);
    check("gap_order", 32'(order_ok), 32'd1);
    for (int i = 0; i < N_BLK; i++) check($sformatf("gap_data%0d", i), 32'(mem[i]), 32'd128);
    check("gap_done", 32'(done_cnt), 32'd1);

    // Asynchronous reset mid-frame.
    pulse_start();
    clear_mon();
    drive_frame(0, 4'd15, 1'b0, 25, -1, -1);
    check("prerst_busy", 32'(bus.busy), 32'd1);
    check("prerst_data", 32'(bus.img_data), 32'd240);
    rst_n = 1'b0;
    #2;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_addr", 32'(bus.img_addr), 32'd0);
    check("arst_data", 32'(bus.img_data), 32'd0);
    check("arst_we", 32'(bus.img_we), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    tick();
    rst_n = 1'b1;
    clear_mon();
    drive_frame(0, 4'd15, 1'b0, -1, -1, -1);
    repeat (4) tick();
    check("postrst_wr_cnt", 32'(wr_cnt), 32'd0);
    check("postrst_done", 32'(done_cnt), 32'd0);
    check("postrst_busy", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
